stalling_data_memory: RTL
=========================

// Module: stalling_data_memory
// PURPOSE
//  Multi-cycle, word-addressed data memory that answers the MEM stage of the 5-stage MIPS core.
//  The core presents address, write data and read/write strobes from its EX/MEM registers.
//  This block raises busy (the core's dataReady / stall input) and freezes the pipeline.
//  It holds busy for a programmable latency, then commits the write or returns the read word.
//  Sits between the EX/MEM and MEM/WB pipeline registers; models slow memory for stall testing.
// PARAMETERS
//  DEPTH      1024  number of 32-bit words; power of two
//  ADDR_BITS  10    log2(DEPTH); index = addr[ADDR_BITS-1:0], upper addr bits ignored (aliasing)
//  LATENCY    2     ACCESS-state cycles per request; legal range 1..15
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   reset, synchronous, active-high
//  addr        in   32  word address (EX_MEM aluResult)
//  wdata       in   32  store data (EX_MEM readData2)
//  mem_write   in   1   store request
//  mem_read    in   1   load request
//  rdata       out  32  load data; registered
//  busy        out  1   high = stall the pipeline (drives core dataReady)
//  access_cnt  out  16  completed-access counter (debug)
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, rdata=0, access_cnt=0, latched request cleared.
//   busy=0 from the following cycle; memory array contents are NOT cleared.
//   Reset mid-access aborts it; a pending write is not committed.
//  req = mem_read | mem_write. If both are set, the access is a write; rdata keeps its previous value.
//  FSM states: IDLE, ACCESS, DONE.
//   IDLE: busy = req (combinational, so the stall takes effect in the cycle the request first appears).
//    If req is set, latch addr/wdata/kind, load cnt=LATENCY-1, go to ACCESS.
//   ACCESS: busy=1; request inputs are ignored (latched copy used).
//    If cnt!=0, decrement cnt.
//    If cnt==0: on write, mem[idx]<=wdata_q; on read, rdata<=mem[idx]. Increment access_cnt (wraps at 16'hFFFF->0). Go to DONE.
//   DONE: busy=0; rdata is valid; the core advances its pipeline at this edge.
//    The request still on the inputs is the one just served and is NOT re-accepted.
//    Unconditionally go to IDLE.
//  Total busy cycles per access = LATENCY+1. A back-to-back request sees one DONE bubble (busy=0) between accesses.
//  rdata holds its value until the next completed read or reset; it is not cleared by writes.
//  No request (req=0) in IDLE: busy=0, no state change, memory untouched.
//  Address aliasing: addr=DEPTH+5 accesses word 5.
// TESTING
//  1. Reset, then addr=4, wdata=32'hDEADBEEF, mem_write=1 held while busy (LATENCY=2):
//     busy high 3 cycles, then one cycle low; mem[4]=DEADBEEF; access_cnt=1.
//  2. Then mem_read=1, addr=4: busy 3 cycles; rdata=32'hDEADBEEF in the DONE cycle; access_cnt=2.
//  3. mem_read and mem_write both set, addr=7, wdata=32'h12345678:
//     mem[7]=12345678; rdata unchanged from previous value (DEADBEEF).
//  4. Write 32'hA5A5A5A5 at addr=9; assert rst on the 2nd busy cycle:
//     busy=0 next cycle; read of addr 9 returns the old contents; access_cnt=0.
//  5. Change addr from 4 to 8 during ACCESS of a read:
//     the returned data is mem[4]; exactly one access is counted.
//  6. Read addr=1029 with DEPTH=1024: returns mem[5]. With LATENCY=1, busy is high exactly 2 cycles.

Source files
------------

// File: rtl/stalling_data_memory_if.sv
// Bus between the MEM stage of the core and the stalling data memory.
// master = core side (drives request), slave = memory side (drives busy/rdata).
interface stalling_data_memory_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata;
  logic        busy;
  logic [15:0] access_cnt;

  modport master (
    output addr,
    output wdata,
    output mem_write,
    output mem_read,
    input  rdata,
    input  busy,
    input  access_cnt
  );

  modport slave (
    input  addr,
    input  wdata,
    input  mem_write,
    input  mem_read,
    output rdata,
    output busy,
    output access_cnt
  );
endinterface

// File: rtl/stalling_data_memory.sv
// Multi-cycle word-addressed data memory that stalls the MEM stage.
// Ports: clk, rst (sync, active-high), bus (slave: addr/wdata/strobes in,
// rdata/busy/access_cnt out). busy is high for LATENCY+1 cycles per access.
module stalling_data_memory #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  stalling_data_memory_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                 state_q;
  logic [3:0]             cnt_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic                   wr_q;
  logic [31:0]            rdata_q;
  logic [15:0]            acc_q;
  logic [31:0]            mem_q [DEPTH];

  logic req;
  logic fire;
  logic unused_addr_hi;

  assign req  = bus.mem_read | bus.mem_write;
  assign fire = (state_q == ACCESS) && (cnt_q == 4'd0);

  // Upper address bits alias onto the same words.
  assign unused_addr_hi = ^bus.addr[31:ADDR_BITS];

  // Stall starts in the same cycle a request appears in IDLE;
  // DONE drops busy so the core advances exactly once.
  assign bus.busy       = (state_q == ACCESS)
                        | ((state_q == IDLE) & req);
  assign bus.rdata      = rdata_q;
  assign bus.access_cnt = acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      acc_q   <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            idx_q   <= bus.addr[ADDR_BITS-1:0];
            wdata_q <= bus.wdata;
            // Write wins when both strobes are set.
            wr_q    <= bus.mem_write;
            cnt_q   <= CNT_INIT;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!wr_q) begin
              rdata_q <= mem_q[idx_q];
            end
            acc_q   <= acc_q + 16'd1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Array is never cleared; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && fire && wr_q) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

endmodule
